controller_reader: RTL and testbench
====================================

# controller_reader

Serial game-controller front end driven by the GPU's `controller_start_fetch` strobe. Once per frame it latches and shifts in two NES-style 8-bit parallel-to-serial controllers (4021-type). It commits both button bytes atomically to CPU-readable registers and returns them on the shared 8-bit bus data lines in the same tri-state style as the GPU's status reads.

## Interface

Parameters:
- `HALF_PERIOD`, default 75: clk cycles per latch/clock half-period (~6 µs at 12.5875 MHz). Legal range is 4..255.

Ports:
- `clk`, in, 1: system clock, 12.5875 MHz.
- `rst`, in, 1: reset, synchronous, active-high.
- `start_fetch`, in, 1: from GPU `controller_start_fetch`. A rising edge starts a fetch.
- `ctrl_latch`, out, 1: parallel-load strobe to both controllers, active-high.
- `ctrl_clk`, out, 1: shift clock to both controllers. Idles high; controllers shift on its rising edge.
- `ctrl_data_1`, in, 1: serial data from controller 1. Asynchronous, active-low (pressed = 0).
- `ctrl_data_2`, in, 1: serial data from controller 2. Same format as `ctrl_data_1`.
- `data_out`, out, 8: bus read data. High-Z unless a select is active.
- `SELECT_controller_1`, in, 1: bus select for the controller 1 register.
- `SELECT_controller_2`, in, 1: bus select for the controller 2 register.
- `busy`, out, 1: high while a fetch is in progress.
- `fetch_done`, out, 1: one-cycle pulse on the commit cycle.

## Operation

- `ctrl_data_1` and `ctrl_data_2` each pass through a 2-flop synchronizer. All sampling uses the synchronized values.
- Edge detect: `start_prev` is registered every cycle and reset to 0. A fetch starts when `start_fetch && !start_prev && state==IDLE`. Rising edges while not in IDLE are ignored and not queued.
- The FSM is IDLE → LATCH → SETTLE → CLK_LO → CLK_HI → (CLK_LO … ) → COMMIT → IDLE.
  - IDLE: `ctrl_latch`=0, `ctrl_clk`=1, `busy`=0.
  - LATCH: `ctrl_latch`=1 for HALF_PERIOD cycles.
  - SETTLE: `ctrl_latch`=0, `ctrl_clk`=1 for HALF_PERIOD cycles. Sample bit 0 on its last cycle.
  - CLK_LO: `ctrl_clk`=0 for HALF_PERIOD cycles.
  - CLK_HI: `ctrl_clk`=1 for HALF_PERIOD cycles. Sample on its last cycle and increment `bit_idx`. After the sample for `bit_idx`==7, go to COMMIT; otherwise go to CLK_LO.
  - COMMIT: one cycle. Copies both shadows to the output registers and pulses `fetch_done`, then goes to IDLE.
- Each fetch generates exactly 7 `ctrl_clk` pulses.
- Sampling: `shadow_n <= {shadow_n[6:0], ~sync_data_n}`. The first bit sampled ends up in bit 7.
- Register bit map (1 = pressed): [7] A, [6] B, [5] Select, [4] Start, [3] Up, [2] Down, [1] Left, [0] Right.
- Read mux (combinational):
  - `SELECT_controller_1` → `buttons_1`.
  - else `SELECT_controller_2` → `buttons_2`.
  - else 8'bz.
  - If both selects are active, controller 1 wins.
- Counters: `half_cnt` is 8-bit and counts 0..HALF_PERIOD-1, reloading to 0 on every state change. `bit_idx` is 3-bit.

## Timing

- Reset values:
  - `ctrl_latch`=0, `ctrl_clk`=1, `busy`=0, `fetch_done`=0.
  - `buttons_1`=`buttons_2`=0x00; shadows 0; `start_prev`=0; state IDLE.
  - `data_out` follows the read mux.
- A high `start_fetch` on the first cycle after reset release counts as a rising edge.
- Rising edge detected at edge T0:
  - `busy` and `ctrl_latch` go high after T0.
  - `fetch_done` is high in cycle T0 + 16·HALF_PERIOD + 1.
  - The new register values are visible from the following cycle.
- A read during the COMMIT cycle returns the old value. Both registers update on the same edge, so no torn frame is possible.
- `rst` mid-fetch aborts the fetch:
  - outputs return to reset values next cycle;
  - registers clear to 0x00;
  - no `fetch_done` is generated.
- The GPU strobe rises once per frame (~60 Hz). A fetch at the default HALF_PERIOD takes ≈1201 cycles, far shorter than a frame.

## Structure

- Package `controller_pkg`:
  - state enum (IDLE, LATCH, SETTLE, CLK_LO, CLK_HI, COMMIT);
  - button bit-index localparams (BTN_A=7 … BTN_RIGHT=0);
  - width constants.
- Sub-module `sync2_m`: 2-flop synchronizer, instantiated once per data line.
- Top-level instantiation: `start_fetch` is wired to the GPU output `controller_start_fetch`. `data_out` shares the bus with the GPU's `data_out`, so the select lines must be mutually exclusive with the GPU's selects.

## Test plan

All scenarios use HALF_PERIOD=4.

- Reset: assert `rst` for 2 cycles. Expect `ctrl_clk`=1, `ctrl_latch`=0, `busy`=0, and selected reads return 0x00. With no select active, `data_out` is Z.
- Single fetch:
  - stimulus: controller 1 model with A and Start pressed; controller 2 model with nothing pressed.
  - expect `ctrl_latch` high for 4 cycles and 7 `ctrl_clk` pulses.
  - expect `fetch_done` at T0+65, `buttons_1`=0x90, `buttons_2`=0x00.
- Retrigger while busy: hold `start_fetch` high for 10 cycles (as the GPU does), and pulse it again at T0+30. Expect exactly one `fetch_done` and no restart.
- Reset mid-fetch: assert `rst` at T0+40. Expect `ctrl_clk`=1 and `busy`=0 next cycle, registers 0x00, and no `fetch_done` pulse.
- Read priority and atomicity:
  - assert both selects → expect `buttons_1` on the bus;
  - read during COMMIT → expect the old value; read the cycle after → expect the new value for both registers.
- All pressed / none pressed: all-low serial input → 0xFF; all-high input → 0x00. Check back-to-back over two frames.

Source files
------------

// File: rtl/controller_pkg.sv
// controller_pkg: shared types and constants for the serial game-controller
// reader.
//   state_t      - fetch sequencer states
//   BTN_*        - bit positions of each button in a committed button byte
//   DATA_W       - width of a button byte / bus read
//   CNT_W, BIT_W - half-period counter and bit index widths
package controller_pkg;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 8;
  localparam int BIT_W  = 3;

  // Button bit map in the CPU-visible registers (1 = pressed).
  localparam int BTN_A      = 7;
  localparam int BTN_B      = 6;
  localparam int BTN_SELECT = 5;
  localparam int BTN_START  = 4;
  localparam int BTN_UP     = 3;
  localparam int BTN_DOWN   = 2;
  localparam int BTN_LEFT   = 1;
  localparam int BTN_RIGHT  = 0;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    SETTLE,
    CLK_LO,
    CLK_HI,
    COMMIT
  } state_t;

endpackage

// File: rtl/controller_reader_if.sv
// controller_reader_if: groups the strobe/status handshake, the controller
// pad signals and the bus selects of the controller reader.
//   slave  - the controller reader itself
//   master - the surrounding system (GPU strobe, bus decoder, controller pads)
interface controller_reader_if;

  logic start_fetch;
  logic busy;
  logic fetch_done;
  logic ctrl_latch;
  logic ctrl_clk;
  logic ctrl_data_1;
  logic ctrl_data_2;
  logic SELECT_controller_1;
  logic SELECT_controller_2;

  modport slave (
    input  start_fetch,
    input  ctrl_data_1,
    input  ctrl_data_2,
    input  SELECT_controller_1,
    input  SELECT_controller_2,
    output busy,
    output fetch_done,
    output ctrl_latch,
    output ctrl_clk
  );

  modport master (
    output start_fetch,
    output ctrl_data_1,
    output ctrl_data_2,
    output SELECT_controller_1,
    output SELECT_controller_2,
    input  busy,
    input  fetch_done,
    input  ctrl_latch,
    input  ctrl_clk
  );

endinterface

// File: rtl/sync2_m.sv
// sync2_m: two-flop synchronizer for one asynchronous input bit.
//   clk - destination clock
//   d   - asynchronous input
//   q   - synchronized output (two clk cycles of latency)
// The flops carry data only, so they have no reset; the reader's own reset
// lasts long enough to flush them before any sample is taken.
module sync2_m (
  input  logic clk,
  input  logic d,
  output logic q
);

  logic sync_p0;
  logic sync_p1;

  always_ff @(posedge clk) begin
    sync_p0 <= d;
    sync_p1 <= sync_p0;
  end

  assign q = sync_p1;

endmodule

// File: rtl/controller_reader.sv
// controller_reader: once per frame, on a rising edge of the GPU's fetch
// strobe, latches two 4021-style serial controllers, shifts in 8 bits from
// each and commits both bytes together to CPU-readable registers.
//   clk      - system clock
//   rst      - synchronous, active-high reset; aborts any fetch in progress
//   bus      - controller_reader_if.slave: start_fetch, busy, fetch_done,
//              ctrl_latch, ctrl_clk, ctrl_data_1/2 (active-low, async),
//              SELECT_controller_1/2
//   data_out - tri-state bus read data; controller 1 wins if both selected
module controller_reader
  import controller_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = 75
) (
  input  logic                clk,
  input  logic                rst,
  controller_reader_if.slave  bus,
  output wire  [DATA_W-1:0]   data_out
);

  localparam logic [CNT_W-1:0] HP_LAST = CNT_W'(HALF_PERIOD - 1);

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   half_cnt;
  logic [BIT_W-1:0]   bit_idx;
  logic               start_prev;
  logic [DATA_W-1:0]  shadow_1;
  logic [DATA_W-1:0]  shadow_2;
  logic [DATA_W-1:0]  buttons_1;
  logic [DATA_W-1:0]  buttons_2;
  logic               sync_data_1;
  logic               sync_data_2;

  logic               half_done;
  logic               start_rise;
  logic               sample;
  logic               latch_c;
  logic               cclk_c;
  logic               busy_c;
  logic               done_c;

  sync2_m u_sync_1 (
    .clk (clk),
    .d   (bus.ctrl_data_1),
    .q   (sync_data_1)
  );

  sync2_m u_sync_2 (
    .clk (clk),
    .d   (bus.ctrl_data_2),
    .q   (sync_data_2)
  );

  assign half_done  = (half_cnt == HP_LAST);
  assign start_rise = bus.start_fetch && !start_prev;

  // Next state and pad/status outputs, all decoded from the current state.
  always_comb begin
    state_nxt = state;
    sample    = 1'b0;
    latch_c   = 1'b0;
    cclk_c    = 1'b1;
    busy_c    = 1'b1;
    done_c    = 1'b0;
    unique case (state)
      IDLE: begin
        busy_c = 1'b0;
        if (start_rise) state_nxt = LATCH;
      end
      LATCH: begin
        latch_c = 1'b1;
        if (half_done) state_nxt = SETTLE;
      end
      SETTLE: begin
        // The controller presents button A right after the latch falls.
        if (half_done) begin
          sample    = 1'b1;
          state_nxt = CLK_LO;
        end
      end
      CLK_LO: begin
        cclk_c = 1'b0;
        if (half_done) state_nxt = CLK_HI;
      end
      CLK_HI: begin
        // Sample just before the next falling edge; the controller shifted
        // on this phase's rising edge, a full half-period earlier.
        if (half_done) begin
          sample    = 1'b1;
          state_nxt = (bit_idx == BIT_W'(7)) ? COMMIT : CLK_LO;
        end
      end
      COMMIT: begin
        done_c    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      half_cnt   <= '0;
      bit_idx    <= '0;
      start_prev <= 1'b0;
      shadow_1   <= '0;
      shadow_2   <= '0;
      buttons_1  <= '0;
      buttons_2  <= '0;
    end else begin
      state      <= state_nxt;
      start_prev <= bus.start_fetch;

      if (state_nxt != state) begin
        half_cnt <= '0;
      end else if (state != IDLE) begin
        half_cnt <= half_cnt + CNT_W'(1);
      end

      if (state == IDLE) begin
        bit_idx <= '0;
      end else if (sample) begin
        bit_idx <= bit_idx + BIT_W'(1);
      end

      // Serial data is active-low; the first bit shifted in lands in bit 7.
      if (sample) begin
        shadow_1 <= {shadow_1[DATA_W-2:0], ~sync_data_1};
        shadow_2 <= {shadow_2[DATA_W-2:0], ~sync_data_2};
      end

      // Both registers update on the same edge so a CPU never sees a frame
      // mixing old and new controller state.
      if (state == COMMIT) begin
        buttons_1 <= shadow_1;
        buttons_2 <= shadow_2;
      end
    end
  end

  assign bus.ctrl_latch = latch_c;
  assign bus.ctrl_clk   = cclk_c;
  assign bus.busy       = busy_c;
  assign bus.fetch_done = done_c;

  assign data_out = bus.SELECT_controller_1 ? buttons_1 :
                    bus.SELECT_controller_2 ? buttons_2 :
                    {DATA_W{1'bz}};

endmodule

// File: tb/tb_controller_reader.sv
// tb_controller_reader: directed bench for controller_reader with
// HALF_PERIOD=4, two behavioural 4021 controller models and a GPU-side
// driver sharing the data bus.
module tb_controller_reader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       gpu_en = 1'b0;
  logic [7:0] gpu_val = 8'h00;
  wire  [7:0] data_bus;

  int vectors = 0;
  int errors  = 0;

  controller_reader_if bus_if ();

  controller_reader #(.HALF_PERIOD(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus_if.slave),
    .data_out (data_bus)
  );

  // Another bus master (the GPU) may drive the shared lines when unselected.
  assign data_bus = gpu_en ? gpu_val : 8'bz;

  always #5 clk = ~clk;

  // Controller models: parallel load while latch is high, shift on the rising
  // edge of ctrl_clk, serial output active-low, unpressed bits fill in.
  logic [7:0] p1 = 8'h00;
  logic [7:0] p2 = 8'h00;
  logic [7:0] sr1 = 8'h00;
  logic [7:0] sr2 = 8'h00;
  logic       cclk_prev = 1'b1;
  int         cclk_rises = 0;
  int         latch_cycles = 0;
  int         done_pulses = 0;

  assign bus_if.ctrl_data_1 = ~sr1[7];
  assign bus_if.ctrl_data_2 = ~sr2[7];

  always @(negedge clk) begin
    if (bus_if.ctrl_latch) begin
      sr1 <= p1;
      sr2 <= p2;
      latch_cycles <= latch_cycles + 1;
    end else if (bus_if.ctrl_clk && !cclk_prev) begin
      sr1 <= {sr1[6:0], 1'b0};
      sr2 <= {sr2[6:0], 1'b0};
    end
    if (bus_if.ctrl_clk && !cclk_prev) cclk_rises <= cclk_rises + 1;
    if (bus_if.fetch_done) done_pulses <= done_pulses + 1;
    cclk_prev <= bus_if.ctrl_clk;
  end

  logic       snap_latch1, snap_busy1, snap_rclk, snap_rbusy;
  logic [7:0] cm_r1, cm_r2, nx_r1, nx_r2;

  task automatic bus_read(input logic s1, input logic s2, output logic [7:0] v);
    bus_if.SELECT_controller_1 = s1;
    bus_if.SELECT_controller_2 = s2;
    #1 v = data_bus;
    bus_if.SELECT_controller_1 = 1'b0;
    bus_if.SELECT_controller_2 = 1'b0;
  endtask

  task automatic gpu_read(input logic [7:0] val, output logic [7:0] v);
    gpu_val = val;
    gpu_en  = 1'b1;
    #1 v = data_bus;
    gpu_en  = 1'b0;
  endtask

  // Raises start_fetch so the edge is detected at T0, then runs 100 cycles.
  // Cycle c is the clock period following edge T0+c-1, observed at negedge.
  task automatic run_fetch(input int hold, input int pulse_at, input int rst_at,
                           output int done_cyc);
    logic [7:0] v;
    @(posedge clk);
    #1 bus_if.start_fetch = 1'b1;
    @(posedge clk);
    done_cyc = -1;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (c == 1) begin
        snap_latch1 = bus_if.ctrl_latch;
        snap_busy1  = bus_if.busy;
      end
      if (bus_if.fetch_done && done_cyc < 0) done_cyc = c;
      if (c == hold) bus_if.start_fetch = 1'b0;
      if (pulse_at > 0 && c == pulse_at) bus_if.start_fetch = 1'b1;
      if (pulse_at > 0 && c == pulse_at + 1) bus_if.start_fetch = 1'b0;
      if (rst_at > 0 && c == rst_at) rst = 1'b1;
      if (rst_at > 0 && c == rst_at + 1) begin
        snap_rclk  = bus_if.ctrl_clk;
        snap_rbusy = bus_if.busy;
      end
      if (rst_at > 0 && c == rst_at + 2) rst = 1'b0;
      if (c == 65) begin
        bus_read(1'b1, 1'b0, v); cm_r1 = v;
        bus_read(1'b0, 1'b1, v); cm_r2 = v;
      end
      if (c == 66) begin
        bus_read(1'b1, 1'b0, v); nx_r1 = v;
        bus_read(1'b0, 1'b1, v); nx_r2 = v;
      end
      @(posedge clk);
    end
  endtask

  task automatic test_reset;
    logic [7:0] v;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vectors++; if (bus_if.ctrl_clk !== 1'b1) begin errors++; $display("FAIL reset_ctrl_clk: got %b expected 1", bus_if.ctrl_clk); end
    vectors++; if (bus_if.ctrl_latch !== 1'b0) begin errors++; $display("FAIL reset_ctrl_latch: got %b expected 0", bus_if.ctrl_latch); end
    vectors++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus_if.busy); end
    vectors++; if (bus_if.fetch_done !== 1'b0) begin errors++; $display("FAIL reset_fetch_done: got %b expected 0", bus_if.fetch_done); end
    bus_read(1'b1, 1'b0, v);
    vectors++; if (v !== 8'h00) begin errors++; $display("FAIL reset_read_1: got %h expected 00", v); end
    bus_read(1'b0, 1'b1, v);
    vectors++; if (v !== 8'h00) begin errors++; $display("FAIL reset_read_2: got %h expected 00", v); end
    gpu_read(8'hA5, v);
    vectors++; if (v !== 8'hA5) begin errors++; $display("FAIL reset_bus_released: got %h expected a5", v); end
  endtask

  task automatic test_single_fetch;
    int done_cyc, l0, k0, d0;
    p1 = 8'h90; p2 = 8'h00;
    l0 = latch_cycles; k0 = cclk_rises; d0 = done_pulses;
    run_fetch(1, 0, 0, done_cyc);
    vectors++; if (snap_busy1 !== 1'b1) begin errors++; $display("FAIL single_busy_t0: got %b expected 1", snap_busy1); end
    vectors++; if (snap_latch1 !== 1'b1) begin errors++; $display("FAIL single_latch_t0: got %b expected 1", snap_latch1); end
    vectors++; if (latch_cycles - l0 != 4) begin errors++; $display("FAIL single_latch_len: got %0d expected 4", latch_cycles - l0); end
    vectors++; if (cclk_rises - k0 != 7) begin errors++; $display("FAIL single_clk_pulses: got %0d expected 7", cclk_rises - k0); end
    vectors++; if (done_cyc != 65) begin errors++; $display("FAIL single_done_cycle: got %0d expected 65", done_cyc); end
    vectors++; if (done_pulses - d0 != 1) begin errors++; $display("FAIL single_done_count: got %0d expected 1", done_pulses - d0); end
    vectors++; if (nx_r1 !== 8'h90) begin errors++; $display("FAIL single_buttons_1: got %h expected 90", nx_r1); end
    vectors++; if (nx_r2 !== 8'h00) begin errors++; $display("FAIL single_buttons_2: got %h expected 00", nx_r2); end
  endtask

  task automatic test_retrigger;
    int done_cyc, k0, d0;
    p1 = 8'h41; p2 = 8'h22;
    k0 = cclk_rises; d0 = done_pulses;
    run_fetch(10, 30, 0, done_cyc);
    vectors++; if (done_pulses - d0 != 1) begin errors++; $display("FAIL retrig_done_count: got %0d expected 1", done_pulses - d0); end
    vectors++; if (done_cyc != 65) begin errors++; $display("FAIL retrig_done_cycle: got %0d expected 65", done_cyc); end
    vectors++; if (cclk_rises - k0 != 7) begin errors++; $display("FAIL retrig_clk_pulses: got %0d expected 7", cclk_rises - k0); end
    vectors++; if (nx_r1 !== 8'h41) begin errors++; $display("FAIL retrig_buttons_1: got %h expected 41", nx_r1); end
    vectors++; if (nx_r2 !== 8'h22) begin errors++; $display("FAIL retrig_buttons_2: got %h expected 22", nx_r2); end
  endtask

  task automatic test_reset_mid_fetch;
    int done_cyc, d0;
    logic [7:0] v;
    p1 = 8'hFF; p2 = 8'hFF;
    d0 = done_pulses;
    run_fetch(1, 0, 40, done_cyc);
    vectors++; if (snap_rclk !== 1'b1) begin errors++; $display("FAIL rstmid_ctrl_clk: got %b expected 1", snap_rclk); end
    vectors++; if (snap_rbusy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", snap_rbusy); end
    vectors++; if (done_pulses - d0 != 0) begin errors++; $display("FAIL rstmid_done_count: got %0d expected 0", done_pulses - d0); end
    @(negedge clk);
    bus_read(1'b1, 1'b0, v);
    vectors++; if (v !== 8'h00) begin errors++; $display("FAIL rstmid_buttons_1: got %h expected 00", v); end
    bus_read(1'b0, 1'b1, v);
    vectors++; if (v !== 8'h00) begin errors++; $display("FAIL rstmid_buttons_2: got %h expected 00", v); end
  endtask

  task automatic test_priority_atomic;
    int done_cyc;
    logic [7:0] v;
    p1 = 8'h3C; p2 = 8'hC3;
    run_fetch(1, 0, 0, done_cyc);
    @(negedge clk);
    bus_read(1'b1, 1'b1, v);
    vectors++; if (v !== 8'h3C) begin errors++; $display("FAIL prio_both_selects: got %h expected 3c", v); end
    bus_read(1'b0, 1'b1, v);
    vectors++; if (v !== 8'hC3) begin errors++; $display("FAIL prio_select_2: got %h expected c3", v); end
    gpu_read(8'h00, v);
    vectors++; if (v !== 8'h00) begin errors++; $display("FAIL prio_bus_released: got %h expected 00", v); end
    p1 = 8'hA5; p2 = 8'h5A;
    run_fetch(1, 0, 0, done_cyc);
    vectors++; if (done_cyc != 65) begin errors++; $display("FAIL atomic_done_cycle: got %0d expected 65", done_cyc); end
    vectors++; if (cm_r1 !== 8'h3C) begin errors++; $display("FAIL atomic_commit_old_1: got %h expected 3c", cm_r1); end
    vectors++; if (cm_r2 !== 8'hC3) begin errors++; $display("FAIL atomic_commit_old_2: got %h expected c3", cm_r2); end
    vectors++; if (nx_r1 !== 8'hA5) begin errors++; $display("FAIL atomic_after_new_1: got %h expected a5", nx_r1); end
    vectors++; if (nx_r2 !== 8'h5A) begin errors++; $display("FAIL atomic_after_new_2: got %h expected 5a", nx_r2); end
  endtask

  task automatic test_back_to_back;
    int done_cyc;
    logic [7:0] v;
    p1 = 8'hFF; p2 = 8'hFF;
    run_fetch(1, 0, 0, done_cyc);
    vectors++; if (done_cyc != 65) begin errors++; $display("FAIL b2b_all_done_cycle: got %0d expected 65", done_cyc); end
    vectors++; if (nx_r1 !== 8'hFF) begin errors++; $display("FAIL b2b_all_buttons_1: got %h expected ff", nx_r1); end
    vectors++; if (nx_r2 !== 8'hFF) begin errors++; $display("FAIL b2b_all_buttons_2: got %h expected ff", nx_r2); end
    @(negedge clk);
    gpu_read(8'h00, v);
    vectors++; if (v !== 8'h00) begin errors++; $display("FAIL b2b_bus_released: got %h expected 00", v); end
    p1 = 8'h00; p2 = 8'h00;
    run_fetch(1, 0, 0, done_cyc);
    vectors++; if (done_cyc != 65) begin errors++; $display("FAIL b2b_none_done_cycle: got %0d expected 65", done_cyc); end
    vectors++; if (cm_r1 !== 8'hFF) begin errors++; $display("FAIL b2b_none_commit_old: got %h expected ff", cm_r1); end
    vectors++; if (nx_r1 !== 8'h00) begin errors++; $display("FAIL b2b_none_buttons_1: got %h expected 00", nx_r1); end
    vectors++; if (nx_r2 !== 8'h00) begin errors++; $display("FAIL b2b_none_buttons_2: got %h expected 00", nx_r2); end
  endtask

  initial begin
    bus_if.start_fetch         = 1'b0;
    bus_if.SELECT_controller_1 = 1'b0;
    bus_if.SELECT_controller_2 = 1'b0;
    test_reset();
    test_single_fetch();
    test_retrigger();
    test_reset_mid_fetch();
    test_priority_atomic();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
